// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } if_state_e;

    localparam int          IF_EX_W     = 3;
    localparam int          EX_ADEF_BIT = 2;
    localparam int          EX_TLB_LSB  = 0;
    localparam logic [31:0] IF_INST_NOP = 32'h0340_0000;

    // Packs the alignment flag above the TLB exception code.
    function automatic logic [IF_EX_W-1:0] make_ex(input logic adef, input logic [1:0] tlb_ex);
        logic [IF_EX_W-1:0] ex;
        ex = {IF_EX_W{1'b0}};
        ex[EX_ADEF_BIT]              = adef;
        ex[EX_TLB_LSB+1:EX_TLB_LSB] = tlb_ex;
        return ex;
    endfunction

endpackage

// File: rtl/if_stage_inst_rsp_filter.sv
// Response filter: remembers a response orphaned by a flush and drops it
// when it finally arrives, so later fetches see only their own data.
module inst_rsp_filter (
    input  logic clk,
    input  logic rst,
    input  logic i_in_wait,
    input  logic i_flush,
    input  logic i_data_ok,
    output logic o_rsp_valid,
    output logic o_discard
);

    logic r_discard;

    // Discard flag: armed by a flush that leaves a response outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_discard <= 1'b0;
        end else if (r_discard) begin
            r_discard <= i_data_ok ? 1'b0 : 1'b1;
        end else if (i_flush && i_in_wait && !i_data_ok) begin
            r_discard <= 1'b1;
        end else begin
            r_discard <= r_discard;
        end
    end

    assign o_rsp_valid = i_data_ok & ~r_discard & i_in_wait & ~i_flush;
    assign o_discard   = r_discard;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues pc on the instruction bus and holds the
// result for decode. Optional alignment check enabled by IF_ADEF_CHECK_EN.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] INST_NOP = IF_INST_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_valid,
    input  logic [31:0]        pc,
    input  logic [1:0]         pc_tlb_ex,
    output logic               pre_if_ready_go,
    output logic               if_allow_in,
    input  logic               flush,
    output logic               inst_req,
    output logic               inst_wr,
    output logic [1:0]         inst_size,
    output logic [31:0]        inst_addr,
    input  logic               inst_addr_ok,
    input  logic               inst_data_ok,
    input  logic [31:0]        inst_rdata,
    input  logic               id_allow_in,
    output logic               if_to_id_valid,
    output logic [31:0]        if_to_id_pc,
    output logic [31:0]        if_to_id_inst,
    output logic [IF_EX_W-1:0] if_to_id_ex
);

    if_state_e          r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_inst;
    logic [IF_EX_W-1:0] r_ex;

    logic               w_adef;
    logic               w_fetch_ex;
    logic [IF_EX_W-1:0] w_ex;
    logic               w_slot_free;
    logic               w_fire;
    logic               w_accept;
    logic               w_ex_go;
    logic               w_rsp_valid;
    logic               w_discard;

    // Alignment exception source.
    always_comb begin
`ifdef IF_ADEF_CHECK_EN
        w_adef = (pc[1:0] != 2'b00);
`else
        w_adef = 1'b0;
`endif
    end

    assign w_ex        = make_ex(w_adef, pc_tlb_ex);
    assign w_fetch_ex  = w_adef | (pc_tlb_ex != 2'b00);
    assign w_slot_free = (r_state == S_IDLE) | ((r_state == S_FULL) & id_allow_in);
    assign w_fire      = ~rst & pc_valid & ~flush & w_slot_free;
    // A pending discard still counts as an outstanding request.
    assign inst_req    = w_fire & ~w_fetch_ex & ~w_discard;
    assign w_accept    = inst_req & inst_addr_ok;
    assign w_ex_go     = w_fire & w_fetch_ex;

    assign pre_if_ready_go = w_accept | w_ex_go;
    assign if_allow_in     = w_slot_free;
    assign inst_wr         = 1'b0;
    assign inst_size       = 2'b10;
    assign inst_addr       = pc;

    inst_rsp_filter u_rsp (
        .clk         (clk),
        .rst         (rst),
        .i_in_wait   (r_state == S_WAIT),
        .i_flush     (flush),
        .i_data_ok   (inst_data_ok),
        .o_rsp_valid (w_rsp_valid),
        .o_discard   (w_discard)
    );

    // Fetch FSM and the instruction slot handed to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= 32'h0000_0000;
            r_inst  <= 32'h0000_0000;
            r_ex    <= {IF_EX_W{1'b0}};
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_rsp_valid) begin
                        r_inst  <= inst_rdata;
                        r_state <= S_FULL;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_IDLE, S_FULL: begin
                    if (w_accept) begin
                        r_state <= S_WAIT;
                        r_pc    <= pc;
                        r_ex    <= w_ex;
                    end else if (w_ex_go) begin
                        r_state <= S_FULL;
                        r_pc    <= pc;
                        r_ex    <= w_ex;
                        r_inst  <= INST_NOP;
                    end else if ((r_state == S_FULL) && id_allow_in) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_to_id_valid = (r_state == S_FULL);
    assign if_to_id_pc    = r_pc;
    assign if_to_id_inst  = r_inst;
    assign if_to_id_ex    = r_ex;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage sitting directly downstream of the PC register and upstream of decode. Takes the next PC from pre-IF, issues it on the instruction SRAM-like bus, and holds the returned instruction until decode accepts it. Drops stale responses after a flush (exception or branch redirect) and carries fetch exceptions forward with the PC.

## Interface
Parameters:
- INST_NOP, 32'h03400000, instruction word forwarded when a fetch exception suppresses the memory request

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_valid  in  1  pre-IF presents a PC this cycle
- pc  in  32  PC to fetch
- pc_tlb_ex  in  2  TLB exception code for pc (0 = none)
- pre_if_ready_go  out  1  pc consumed this cycle
- if_allow_in  out  1  IF can accept a new PC
- flush  in  1  wb_ex or branch redirect; kills IF contents
- inst_req  out  1  memory request
- inst_wr  out  1  tied 0
- inst_size  out  2  tied 2'b10
- inst_addr  out  32  equals pc
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  32  read data
- id_allow_in  in  1  decode accepts
- if_to_id_valid  out  1  instruction held for decode
- if_to_id_pc  out  32
- if_to_id_inst  out  32
- if_to_id_ex  out  3  {adef, tlb_ex[1:0]}

## Operation
- States: IDLE (empty), WAIT (address accepted, data outstanding), FULL (instruction held).
- fetch_ex = pc_tlb_ex != 0 (plus adef, see Configuration).
- inst_req = pc_valid & !flush & !fetch_ex & (IDLE | (FULL & id_allow_in)).
- accept = inst_req & inst_addr_ok: latch pc, pc_tlb_ex -> WAIT.
- Exception path: pc_valid & !flush & fetch_ex & slot free -> no request; latch pc, ex, inst=INST_NOP -> FULL directly.
- pre_if_ready_go = accept | exception path.
- WAIT: inst_data_ok & discard==0 -> latch inst_rdata -> FULL.
- FULL: if_to_id_valid=1; id_allow_in -> handshake; next state IDLE, or WAIT/FULL on same-cycle accept/exception path.
- if_allow_in = IDLE | (FULL & id_allow_in).
- discard flag (1 bit): set by flush in WAIT unless inst_data_ok arrives the same cycle; while set, the next inst_data_ok is dropped and clears it; the stage stays IDLE.
- flush: state -> IDLE regardless of current state; no request issued that cycle; FULL contents discarded.
- Responses are in order; at most one request outstanding (no accept while WAIT).

## Timing
- Reset: state IDLE, discard 0, if_to_id_valid 0, pc/inst/ex 0, inst_req 0, pre_if_ready_go 0.
- Best case: accept cycle t, data_ok t+1, if_to_id_valid at t+2.
- Exception path: if_to_id_valid one cycle after pc consumed.
- Back-to-back: FULL & id_allow_in & accept -> one fetch per cycle pair with single outstanding.
- flush & data_ok same cycle in WAIT: data dropped, discard stays 0.
- flush while discard set: discard stays set (still one outstanding).
- rst mid-WAIT: state and discard cleared; testbench must also reset memory.

## Configuration
- IF_ADEF_CHECK_EN defined: pc[1:0] != 0 sets adef, joins fetch_ex, takes exception path (ex = {1, pc_tlb_ex}).
- Undefined: no alignment check; adef bit tied 0; misaligned pc fetched normally.

## Structure
- Package if_pkg: state enum (IDLE/WAIT/FULL), IF_EX_W=3, EX bit positions, INST_NOP default.
- One sub-module natural: inst_rsp_filter (discard flag, data_ok gating).

## Test plan
- pc 0x1c000000, addr_ok same cycle, data_ok next with 0x02800421 -> if_to_id_valid two cycles after accept, inst 0x02800421, ex 0.
- FULL with id_allow_in=0 for 3 cycles -> outputs stable, if_allow_in=0, inst_req=0.
- flush in WAIT, data_ok 2 cycles later -> data dropped, if_to_id_valid stays 0; next pc fetched normally.
- flush same cycle as data_ok -> data dropped, discard remains 0.
- pc_tlb_ex=2'b01 -> no inst_req, if_to_id_inst=0x03400000, ex=3'b001.
- IF_ADEF_CHECK_EN, pc 0x1c000002 -> no inst_req, ex=3'b100; undefined -> request issued.
